// File: rtl/pipe_bubble_ctrl.sv
// Pipeline stall/flush sequencer: picks latch load enables and NOP-bubble selects each cycle.
// Optional perf counters (stall_cycles, flush_events) are built only when PIPE_PERF_CNT_EN is defined.
module pipe_bubble_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int FLUSH_DEPTH = 3,
  parameter int LU_BUBBLES  = 1,
  parameter int LU_STAGE    = 1,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_stall,
  input  logic                  branch_taken,
  input  logic                  load_use_hazard,
  output logic                  load_pc,
  output logic [NUM_STAGES-1:0] load_latch,
  output logic [NUM_STAGES-1:0] bubble_sel,
  output logic                  busy,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] LU_STALL = 1'b1;

  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("pipe_bubble_ctrl: NUM_STAGES must be 2..8");
  end
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > NUM_STAGES) begin : g_bad_flush_depth
    $error("pipe_bubble_ctrl: FLUSH_DEPTH must be 1..NUM_STAGES");
  end
  if (LU_BUBBLES < 1 || LU_BUBBLES > 15) begin : g_bad_lu_bubbles
    $error("pipe_bubble_ctrl: LU_BUBBLES must be 1..15");
  end
  if (LU_STAGE < 1 || LU_STAGE > NUM_STAGES - 1) begin : g_bad_lu_stage
    $error("pipe_bubble_ctrl: LU_STAGE must be 1..NUM_STAGES-1");
  end
  if ((1 << CNT_W) <= LU_BUBBLES) begin : g_bad_cnt_w
    $error("pipe_bubble_ctrl: CNT_W too narrow for LU_BUBBLES");
  end

  logic [0:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [0:0]            w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_STAGES-1:0] w_lu_load;
  logic [NUM_STAGES-1:0] w_lu_sel;
  logic [NUM_STAGES-1:0] w_flush_sel;
  logic                  w_flush;

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_lu_load[i]   = (i >= LU_STAGE);
      w_lu_sel[i]    = (i == LU_STAGE);
      w_flush_sel[i] = (i < FLUSH_DEPTH);
    end
  end

  assign w_flush = !mem_stall && branch_taken;

  // Outputs are a pure function of state and inputs; reset overrides everything.
  always_comb begin
    load_pc    = 1'b1;
    load_latch = '1;
    bubble_sel = '0;
    busy       = (r_state == LU_STALL);
    if (rst) begin
      load_pc    = 1'b0;
      load_latch = '0;
      bubble_sel = '1;
      busy       = 1'b0;
    end else if (mem_stall) begin
      load_pc    = 1'b0;
      load_latch = '0;
    end else if (branch_taken) begin
      bubble_sel = w_flush_sel;
    end else if (r_state == LU_STALL || load_use_hazard) begin
      load_pc    = 1'b0;
      load_latch = w_lu_load;
      bubble_sel = w_lu_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (mem_stall) begin
      w_state_nxt = r_state;
    end else if (branch_taken) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (r_state == LU_STALL) begin
      if (r_cnt == CNT_W'(1)) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end else if (load_use_hazard && LU_BUBBLES > 1) begin
      // The hazard cycle itself is the first bubble, so LU_BUBBLES-1 remain.
      w_state_nxt = LU_STALL;
      w_cnt_nxt   = CNT_W'(LU_BUBBLES - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!load_pc) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush)  r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
